pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the 16-bit five-stage core. Drives enable and flush of the PC and the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Resolves three conditions in fixed priority:
- multi-cycle data-memory waits;
- EX-stage redirects;
- load-use hazards.

It also runs the HALT drain sequence and keeps a saturating stall counter.

## Interface
Parameters:
- CNT_W, 16, width of stall_cycles counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- idex_mem_read  in  1  instruction in EX is a load
- idex_rd  in  3  destination register of instruction in EX
- ifid_rs, ifid_rt  in  3 each  source registers of instruction in ID
- ifid_rs_vld, ifid_rt_vld  in  1 each  source is actually read
- ifid_halt  in  1  HALT decoded in ID
- ex_redirect  in  1  branch taken / jump resolved in EX (PC target supplied elsewhere)
- dmem_req  in  1  MEM-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- wb_halt  in  1  HALT is in WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  active-high synchronous clear into register (ORed with the register's reset)
- halted  out  1  core stopped
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
FSM states: RUN, MEM_WAIT, DRAIN, HALTED.

Derived signals:
- mem_stall = dmem_req & ~dmem_ready
- load_use = idex_mem_read & ((ifid_rs_vld & ifid_rs==idex_rd) | (ifid_rt_vld & ifid_rt==idex_rd))

Priority in RUN/DRAIN, highest first:
1. mem_stall. All en = 0 except memwb_en = 1 with memwb_flush = 1: one bubble into WB per wait cycle, no repeated writeback. Move to MEM_WAIT.
2. ex_redirect. pc_en = 1. ifid_flush = idex_flush = 1, giving two bubbles. exmem/memwb advance. In DRAIN, return to RUN: the HALT was wrong-path.
3. load_use. pc_en = ifid_en = 0. idex_flush = 1. Later stages advance.
4. ifid_halt in RUN. Go to DRAIN. HALT advances into EX.
5. Otherwise all en = 1, all flush = 0.

MEM_WAIT:
- Same outputs as priority 1 while mem_stall holds.
- When dmem_ready = 1: all en = 1 and the stage advances that cycle. Next state is RUN, or DRAIN if entered from DRAIN (track with a 1-bit return flag).
- Redirect or load-use held during the wait is applied on the first cycle after the wait. EX is frozen, so its inputs persist.

DRAIN:
- pc_en = 0 and ifid_flush = 1 every cycle; no fetch past the HALT.
- Other stages advance unless priority 1–3 applies.
- wb_halt = 1 → HALTED.

HALTED:
- All en = 0, all flush = 0, halted = 1.
- Exit only by reset.

stall_cycles:
- Increments each cycle where mem_stall or load_use causes a stall (the pc_en = 0 cases, excluding DRAIN/HALTED).
- Saturates at all-ones.

## Timing
- While rst = 0: all en = 0, all flush = 1, halted = 0, stall_cycles = 0, state = RUN.
- First cycle after rst = 1: RUN decode.
- All en/flush outputs are combinational from state and inputs; zero-cycle latency to the stage registers.
- State, return flag, halted and stall_cycles are registered.
- halted rises the cycle after wb_halt is seen in DRAIN.
- Load-use costs exactly one bubble; redirect costs exactly two.
- mem_stall with ex_redirect in the same cycle: stall only; redirect is applied on the ready cycle + 1.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN with the counter cleared.

## Structure
- Shared package `pipe_pkg` holds:
  - state enum (RUN = 2'd0, MEM_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3);
  - REG_IDX_W = 3.
- One sub-module, `hazard_detect`: combinational load_use compare.
- FSM, output decode and counter live in pipe_ctrl.

## Test plan
- Load r3 in EX, ID reads r3 via rs (vld = 1) → pc_en = ifid_en = 0, idex_flush = 1 for exactly one cycle; stall_cycles 0→1. Same with rs_vld = 0 → no stall.
- dmem_req = 1, dmem_ready low for 3 cycles → 3 cycles of all-en-0 with memwb bubble; state MEM_WAIT; ready cycle all en = 1; stall_cycles += 3.
- ex_redirect together with load_use → ifid_flush = idex_flush = 1, pc_en = 1, no load-use stall counted.
- ifid_halt → DRAIN, pc_en = 0; wb_halt 3 cycles later → halted = 1 next cycle, all en = 0. Redirect mid-DRAIN → back to RUN, halted stays 0.
- Preload stall_cycles to all-ones via repeated stalls with CNT_W = 4 → holds 4'hF. rst low mid-MEM_WAIT → next cycle RUN, counter 0, outputs at reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the five-stage core pipeline sequencer.
//   state_e  - sequencer FSM states
//   en_t     - per-register load enables {pc, ifid, idex, exmem, memwb}
//   flush_t  - per-register synchronous clears {ifid, idex, exmem, memwb}
package pipe_pkg;

  localparam int REG_IDX_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } en_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } flush_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline sequencer and the datapath.
//   hazard/status inputs : idex_*, ifid_*, ex_redirect, dmem_*, wb_halt
//   control outputs      : *_en, *_flush, halted, stall_cycles
// Modports: master = sequencer (drives controls), slave = datapath.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic                 idex_mem_read;
  logic [REG_IDX_W-1:0] idex_rd;
  logic [REG_IDX_W-1:0] ifid_rs;
  logic [REG_IDX_W-1:0] ifid_rt;
  logic                 ifid_rs_vld;
  logic                 ifid_rt_vld;
  logic                 ifid_halt;
  logic                 ex_redirect;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 wb_halt;

  logic                 pc_en;
  logic                 ifid_en;
  logic                 idex_en;
  logic                 exmem_en;
  logic                 memwb_en;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 exmem_flush;
  logic                 memwb_flush;
  logic                 halted;
  logic [CNT_W-1:0]     stall_cycles;

  modport master (
    input  idex_mem_read, idex_rd, ifid_rs, ifid_rt, ifid_rs_vld, ifid_rt_vld,
           ifid_halt, ex_redirect, dmem_req, dmem_ready, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles
  );

  modport slave (
    output idex_mem_read, idex_rd, ifid_rs, ifid_rt, ifid_rs_vld, ifid_rt_vld,
           ifid_halt, ex_redirect, dmem_req, dmem_ready, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use check.
//   load_use = 1 when the load in EX writes a register that ID actually reads.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                 idex_mem_read,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic [REG_IDX_W-1:0] ifid_rs,
  input  logic [REG_IDX_W-1:0] ifid_rt,
  input  logic                 ifid_rs_vld,
  input  logic                 ifid_rt_vld,
  output logic                 load_use
);

  assign load_use = idex_mem_read &
                    ((ifid_rs_vld & (ifid_rs == idex_rd)) |
                     (ifid_rt_vld & (ifid_rt == idex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the five-stage core.
//   clk, rst  - clock; synchronous active-low reset
//   bus       - pipe_ctrl_if.master: hazard/status in, enables/flushes out,
//               halted and saturating stall_cycles out
// Priority in RUN/DRAIN: mem_stall > ex_redirect > load_use > ifid_halt.
// Enables/flushes are combinational; state, return flag, halted and the
// counter are registered.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  state_e           state_q, state_n;
  logic             ret_q, ret_n;     // MEM_WAIT was entered from DRAIN
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stall_inc;
  logic             mem_stall;
  logic             load_use;
  en_t              en;
  flush_t           fl;

  assign mem_stall = bus.dmem_req & ~bus.dmem_ready;

  hazard_detect u_hazard (
    .idex_mem_read (bus.idex_mem_read),
    .idex_rd       (bus.idex_rd),
    .ifid_rs       (bus.ifid_rs),
    .ifid_rt       (bus.ifid_rt),
    .ifid_rs_vld   (bus.ifid_rs_vld),
    .ifid_rt_vld   (bus.ifid_rt_vld),
    .load_use      (load_use)
  );

  always_comb begin
    en        = '0;
    fl        = '0;
    state_n   = state_q;
    ret_n     = ret_q;
    stall_inc = 1'b0;
    if (!rst) begin
      fl      = '1;
      state_n = RUN;
      ret_n   = 1'b0;
    end else begin
      case (state_q)
        RUN, DRAIN: begin
          if (mem_stall) begin
            // freeze everything; one bubble per wait cycle into WB
            en.memwb  = 1'b1;
            fl.memwb  = 1'b1;
            state_n   = MEM_WAIT;
            ret_n     = (state_q == DRAIN);
            stall_inc = (state_q == RUN);
          end else if (bus.ex_redirect) begin
            en      = '1;
            fl.ifid = 1'b1;
            fl.idex = 1'b1;
            state_n = RUN;  // a HALT behind a taken redirect was wrong-path
          end else if (load_use) begin
            en        = '1;
            en.pc     = 1'b0;
            en.ifid   = 1'b0;
            fl.idex   = 1'b1;
            stall_inc = (state_q == RUN);
          end else begin
            en = '1;
            if (state_q == RUN && bus.ifid_halt) state_n = DRAIN;
          end
          if (state_q == DRAIN) begin
            // no fetch past the HALT; the PC still loads a redirect target
            fl.ifid = 1'b1;
            if (!bus.ex_redirect || mem_stall) en.pc = 1'b0;
            if (bus.wb_halt && !mem_stall) state_n = HALTED;
          end
        end
        MEM_WAIT: begin
          // EX is frozen, so a pending redirect/load-use is seen again the
          // cycle after the wait ends; it is deliberately ignored here.
          fl.ifid = ret_q;
          if (mem_stall) begin
            en.memwb  = 1'b1;
            fl.memwb  = 1'b1;
            stall_inc = ~ret_q;
          end else begin
            en      = '1;
            en.pc   = ~ret_q;
            state_n = ret_q ? DRAIN : RUN;
            ret_n   = 1'b0;
          end
        end
        HALTED: ;
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      ret_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      ret_q    <= ret_n;
      halted_q <= (state_n == HALTED);
      if (stall_inc && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc_en        = en.pc;
  assign bus.ifid_en      = en.ifid;
  assign bus.idex_en      = en.idex;
  assign bus.exmem_en     = en.exmem;
  assign bus.memwb_en     = en.memwb;
  assign bus.ifid_flush   = fl.ifid;
  assign bus.idex_flush   = fl.idex;
  assign bus.exmem_flush  = fl.exmem;
  assign bus.memwb_flush  = fl.memwb;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl with a 4-bit stall counter.
// en vector = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [4:0] en_v;
  logic [3:0] fl_v;
  assign en_v = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
  assign fl_v = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.idex_mem_read = 1'b0; bus.idex_rd = 3'd0;
    bus.ifid_rs = 3'd0; bus.ifid_rt = 3'd0;
    bus.ifid_rs_vld = 1'b0; bus.ifid_rt_vld = 1'b0;
    bus.ifid_halt = 1'b0; bus.ex_redirect = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0; bus.wb_halt = 1'b0;
  endtask

  task automatic set_lu();
    bus.idex_mem_read = 1'b1; bus.idex_rd = 3'd3;
    bus.ifid_rs = 3'd3; bus.ifid_rs_vld = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick(); tick();
    // reset values
    chk("rst_en", 16'(en_v), 16'h00);
    chk("rst_fl", 16'(fl_v), 16'hF);
    chk("rst_halted", 16'(bus.halted), 16'h0);
    chk("rst_cnt", 16'(bus.stall_cycles), 16'h0);
    rst = 1'b1;
    tick();
    #1 chk("run_en", 16'(en_v), 16'h1F);
    chk("run_fl", 16'(fl_v), 16'h0);

    // load-use on rs
    set_lu();
    #1 chk("lu_en", 16'(en_v), 16'h07);
    chk("lu_fl", 16'(fl_v), 16'h4);
    tick();
    chk("lu_cnt", 16'(bus.stall_cycles), 16'h1);
    bus.idex_mem_read = 1'b0;  // bubble now in EX
    #1 chk("lu_one_en", 16'(en_v), 16'h1F);
    set_lu(); bus.ifid_rs_vld = 1'b0;
    #1 chk("lu_novld_en", 16'(en_v), 16'h1F);
    tick();
    chk("lu_novld_cnt", 16'(bus.stall_cycles), 16'h1);
    idle();

    // 3-cycle data memory wait
    bus.dmem_req = 1'b1;
    #1 chk("mw1_en", 16'(en_v), 16'h01);
    chk("mw1_fl", 16'(fl_v), 16'h1);
    tick();
    chk("mw_state", 16'(dut.state_q), 16'(MEM_WAIT));
    chk("mw2_en", 16'(en_v), 16'h01);
    tick();
    chk("mw3_fl", 16'(fl_v), 16'h1);
    tick();
    chk("mw_cnt", 16'(bus.stall_cycles), 16'h4);
    bus.dmem_ready = 1'b1;
    #1 chk("mw_rdy_en", 16'(en_v), 16'h1F);
    chk("mw_rdy_fl", 16'(fl_v), 16'h0);
    tick();
    chk("mw_back_state", 16'(dut.state_q), 16'(RUN));
    idle();

    // redirect with load-use: redirect wins, not counted
    set_lu(); bus.ex_redirect = 1'b1;
    #1 chk("rdlu_en", 16'(en_v), 16'h1F);
    chk("rdlu_fl", 16'(fl_v), 16'hC);
    tick();
    chk("rdlu_cnt", 16'(bus.stall_cycles), 16'h4);
    idle();

    // mem stall with redirect: redirect applied after ready cycle
    bus.dmem_req = 1'b1; bus.ex_redirect = 1'b1;
    #1 chk("msrd_en", 16'(en_v), 16'h01);
    tick();
    bus.dmem_ready = 1'b1;
    #1 chk("msrd_rdy_fl", 16'(fl_v), 16'h0);
    chk("msrd_rdy_en", 16'(en_v), 16'h1F);
    tick();
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    #1 chk("msrd_after_fl", 16'(fl_v), 16'hC);
    chk("msrd_cnt", 16'(bus.stall_cycles), 16'h5);
    tick();
    idle();

    // HALT drain
    bus.ifid_halt = 1'b1;
    #1 chk("halt_id_en", 16'(en_v), 16'h1F);
    tick();
    bus.ifid_halt = 1'b0;
    #1 chk("drain_en", 16'(en_v), 16'h0F);
    chk("drain_fl", 16'(fl_v), 16'h8);
    tick(); tick();
    bus.wb_halt = 1'b1;
    #1 chk("drain_wb_halted", 16'(bus.halted), 16'h0);
    tick();
    bus.wb_halt = 1'b0; bus.ex_redirect = 1'b1;
    #1 chk("halted", 16'(bus.halted), 16'h1);
    chk("halted_en", 16'(en_v), 16'h00);
    chk("halted_fl", 16'(fl_v), 16'h0);
    tick();
    chk("halted_stay", 16'(bus.halted), 16'h1);
    idle();

    // reset, then redirect mid-DRAIN cancels the drain
    rst = 1'b0; tick(); rst = 1'b1;
    bus.ifid_halt = 1'b1;
    tick();
    bus.ifid_halt = 1'b0; bus.ex_redirect = 1'b1;
    #1 chk("drain_rd_en", 16'(en_v), 16'h1F);
    chk("drain_rd_fl", 16'(fl_v), 16'hC);
    tick();
    bus.ex_redirect = 1'b0;
    #1 chk("drain_rd_run_en", 16'(en_v), 16'h1F);
    chk("drain_rd_halted", 16'(bus.halted), 16'h0);
    tick(); tick(); tick(); tick();
    chk("drain_rd_stay", 16'(bus.halted), 16'h0);

    // saturation of the 4-bit counter
    set_lu();
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 16'(bus.stall_cycles), 16'hE);
    tick();
    chk("sat_15", 16'(bus.stall_cycles), 16'hF);
    tick(); tick(); tick();
    chk("sat_hold", 16'(bus.stall_cycles), 16'hF);
    idle();

    // reset mid-MEM_WAIT
    bus.dmem_req = 1'b1;
    tick();
    chk("mw_rst_pre", 16'(dut.state_q), 16'(MEM_WAIT));
    rst = 1'b0;
    #1 chk("mw_rst_en", 16'(en_v), 16'h00);
    chk("mw_rst_fl", 16'(fl_v), 16'hF);
    tick();
    chk("mw_rst_state", 16'(dut.state_q), 16'(RUN));
    chk("mw_rst_cnt", 16'(bus.stall_cycles), 16'h0);
    chk("mw_rst_halted", 16'(bus.halted), 16'h0);
    idle();
    rst = 1'b1;
    #1 chk("post_rst_en", 16'(en_v), 16'h1F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
